tpu_program_loader: RTL and testbench

- Host-side controller for the 4-bit processing unit and its 64x8 instruction memory.
- Accepts nibble-wide commands over a valid/ready handshake. Commands set a load address, write and read back instruction bytes, and start or halt the CPU.
- The CPU is held in reset while halted. While halted the loader owns the memory address; while running the CPU's program counter owns it.

---
 rtl/tpu_program_loader_if.sv | 31 +++
 rtl/tpu_program_loader.sv | 190 +++++++++++++++++++
 tb/tb_tpu_program_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : tpu_program_loader_if
// Description : Host-side command channel of the program loader.
//               host_valid/host_ready  command handshake
//               host_cmd [1:0]         00 ADDR_HI, 01 ADDR_LO,
//                                      10 WRITE_NIBBLE, 11 CONTROL
//               host_data[3:0]         command payload
//               rd_valid / rd_data     one-cycle readback pulse and byte
//               master = host side, slave = loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tpu_program_loader_if;
  logic       host_valid;
  logic       host_ready;
  logic [1:0] host_cmd;
  logic [3:0] host_data;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (
    output host_valid, host_cmd, host_data,
    input  host_ready, rd_valid, rd_data
  );

  modport slave (
    input  host_valid, host_cmd, host_data,
    output host_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/tpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tpu_program_loader
// Description : Host-side controller for the 4-bit CPU and its instruction
//               memory. Loads/reads instruction bytes nibble by nibble and
//               starts/halts the CPU, which is held in reset while halted.
// Ports       : clk          system clock (posedge)
//               reset        asynchronous, active-low reset
//               host         command channel (slave modport)
//               cpu_addr     CPU program counter
//               cpu_reset_n  active-low CPU reset (registered)
//               mem_raddr    memory read address (loader or CPU)
//               mem_rdata    memory read data (async read)
//               mem_we/mem_waddr/mem_wdata  synchronous write port
//               running      high while in RUN
//               done         one-cycle pulse on auto-halt at CYCLE_LIMIT
//               err          sticky: non-CONTROL command accepted in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_program_loader #(
  parameter int ADDR_W      = 6,
  parameter int CYCLE_W     = 16,
  parameter int CYCLE_LIMIT = 0
) (
  input  wire logic                clk,
  input  wire logic                reset,
  tpu_program_loader_if.slave      host,
  input  wire logic [ADDR_W-1:0]   cpu_addr,
  output logic                     cpu_reset_n,
  output logic      [ADDR_W-1:0]   mem_raddr,
  input  wire logic [7:0]          mem_rdata,
  output logic                     mem_we,
  output logic      [ADDR_W-1:0]   mem_waddr,
  output logic      [7:0]          mem_wdata,
  output logic                     running,
  output logic                     done,
  output logic                     err
);

  localparam logic [1:0] S_HALT      = 2'd0;
  localparam logic [1:0] S_WR_COMMIT = 2'd1;
  localparam logic [1:0] S_RD        = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [1:0] C_CMD_ADDR_HI = 2'b00;
  localparam logic [1:0] C_CMD_ADDR_LO = 2'b01;
  localparam logic [1:0] C_CMD_WRITE   = 2'b10;
  localparam logic [1:0] C_CMD_CONTROL = 2'b11;

  localparam logic [3:0] C_CTL_HALT = 4'b0000;
  localparam logic [3:0] C_CTL_RUN  = 4'b0001;
  localparam logic [3:0] C_CTL_READ = 4'b0011;

  // Last counter value of a limited run; unused when CYCLE_LIMIT is 0.
  localparam logic [CYCLE_W-1:0] C_LIMIT_M1 =
      (CYCLE_LIMIT == 0) ? '0 : CYCLE_W'(CYCLE_LIMIT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [ADDR_W-1:0]  r_laddr;
  logic               r_phase;
  logic [3:0]         r_hi_nib;
  logic [CYCLE_W-1:0] r_cnt;
  logic               r_rd_valid;
  logic [7:0]         r_rd_data;

  logic w_accept;
  logic w_is_ctrl;
  logic w_limit_hit;

  // Ready depends only on state, never on host_valid.
  assign host.host_ready = (r_state == S_HALT) || (r_state == S_RUN);
  assign host.rd_valid   = r_rd_valid;
  assign host.rd_data    = r_rd_data;

  assign w_accept    = host.host_valid && host.host_ready;
  assign w_is_ctrl   = (host.host_cmd == C_CMD_CONTROL);
  assign w_limit_hit = (CYCLE_LIMIT != 0) && (r_cnt == C_LIMIT_M1);

  assign mem_raddr = (r_state == S_RUN) ? cpu_addr : r_laddr;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HALT: begin
        if (w_accept) begin
          if (w_is_ctrl) begin
            if (host.host_data == C_CTL_RUN)
              w_next_state = S_RUN;
            else if (host.host_data == C_CTL_READ)
              w_next_state = S_RD;
          end else if (host.host_cmd == C_CMD_WRITE && r_phase) begin
            w_next_state = S_WR_COMMIT;
          end
        end
      end
      S_WR_COMMIT: w_next_state = S_HALT;
      S_RD:        w_next_state = S_HALT;
      S_RUN: begin
        if (w_limit_hit)
          w_next_state = S_HALT;
        else if (w_accept && w_is_ctrl && host.host_data == C_CTL_HALT)
          w_next_state = S_HALT;
      end
      default:     w_next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_HALT;
      r_laddr     <= '0;
      r_phase     <= 1'b0;
      r_hi_nib    <= 4'h0;
      r_cnt       <= '0;
      cpu_reset_n <= 1'b0;
      running     <= 1'b0;
      mem_we      <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Both track the state being entered, so they are valid from the
      // first RUN cycle and drop at the edge that leaves RUN.
      cpu_reset_n <= (w_next_state == S_RUN);
      running     <= (w_next_state == S_RUN);
      r_rd_valid  <= 1'b0;
      done        <= 1'b0;

      case (r_state)
        S_HALT: begin
          if (w_accept) begin
            case (host.host_cmd)
              C_CMD_ADDR_HI: begin
                r_laddr[ADDR_W-1:4] <= host.host_data[ADDR_W-5:0];
                r_phase             <= 1'b0;
              end
              C_CMD_ADDR_LO: begin
                r_laddr[3:0] <= host.host_data;
                r_phase      <= 1'b0;
              end
              C_CMD_WRITE: begin
                if (!r_phase) begin
                  r_hi_nib <= host.host_data;
                  r_phase  <= 1'b1;
                end else begin
                  mem_wdata <= {r_hi_nib, host.host_data};
                  mem_waddr <= r_laddr;
                  mem_we    <= 1'b1;
                  r_phase   <= 1'b0;
                end
              end
              C_CMD_CONTROL: begin
                if (host.host_data == C_CTL_RUN) begin
                  r_phase <= 1'b0;
                  r_cnt   <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        S_WR_COMMIT: begin
          mem_we  <= 1'b0;
          r_laddr <= r_laddr + 1'b1;
        end
        S_RD: begin
          r_rd_data  <= mem_rdata;
          r_rd_valid <= 1'b1;
          r_laddr    <= r_laddr + 1'b1;
        end
        S_RUN: begin
          if (r_cnt != {CYCLE_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
          if (w_limit_hit)
            done <= 1'b1;
          if (w_accept && !w_is_ctrl)
            err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_program_loader
// Description : Directed self-checking bench. Two loader instances: one with
//               unlimited run (dut) and one with a 10-cycle run limit
//               (dut_lim). A 64x8 memory model backs the unlimited instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_program_loader;

  localparam logic [1:0] C_HI = 2'b00;
  localparam logic [1:0] C_LO = 2'b01;
  localparam logic [1:0] C_WR = 2'b10;
  localparam logic [1:0] C_CT = 2'b11;

  logic clk;
  logic reset;

  int tests;
  int fails;

  // Unlimited instance
  tpu_program_loader_if h0 ();
  logic [5:0] cpu_addr;
  logic       cpu_reset_n;
  logic [5:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       running;
  logic       done;
  logic       err;
  logic [7:0] mem [0:63];

  // Limited instance
  tpu_program_loader_if hl ();
  logic [5:0] cpu_addr_l;
  logic       cpu_reset_n_l;
  logic [5:0] mem_raddr_l;
  logic [7:0] mem_rdata_l;
  logic       mem_we_l;
  logic [5:0] mem_waddr_l;
  logic [7:0] mem_wdata_l;
  logic       running_l;
  logic       done_l;
  logic       err_l;

  tpu_program_loader #(.ADDR_W(6), .CYCLE_W(16), .CYCLE_LIMIT(0)) dut (
    .clk(clk), .reset(reset), .host(h0),
    .cpu_addr(cpu_addr), .cpu_reset_n(cpu_reset_n),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .running(running), .done(done), .err(err)
  );

  tpu_program_loader #(.ADDR_W(6), .CYCLE_W(16), .CYCLE_LIMIT(10)) dut_lim (
    .clk(clk), .reset(reset), .host(hl),
    .cpu_addr(cpu_addr_l), .cpu_reset_n(cpu_reset_n_l),
    .mem_raddr(mem_raddr_l), .mem_rdata(mem_rdata_l),
    .mem_we(mem_we_l), .mem_waddr(mem_waddr_l), .mem_wdata(mem_wdata_l),
    .running(running_l), .done(done_l), .err(err_l)
  );

  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata   = mem[mem_raddr];
  assign mem_rdata_l = {2'b00, mem_raddr_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command and return 1 time unit after the transfer edge.
  task automatic send(input bit sel, input logic [1:0] c, input logic [3:0] d);
    int n;
    @(negedge clk);
    if (sel) begin
      hl.host_valid = 1'b1; hl.host_cmd = c; hl.host_data = d;
    end else begin
      h0.host_valid = 1'b1; h0.host_cmd = c; h0.host_data = d;
    end
    n = 0;
    while (!(sel ? hl.host_ready : h0.host_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL send_timeout: host_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    h0.host_valid = 1'b0;
    hl.host_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    tests++;
    if ({cpu_reset_n, mem_we, h0.rd_valid, done, err, running} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {cpu_reset_n, mem_we, h0.rd_valid, done, err, running});
    end
    tests++;
    if ({mem_waddr, mem_wdata, h0.rd_data, mem_raddr} !== 28'h0) begin
      fails++;
      $display("FAIL reset_buses: waddr=%h wdata=%h rd_data=%h raddr=%h required all 0",
               mem_waddr, mem_wdata, h0.rd_data, mem_raddr);
    end
    tests++;
    if (h0.host_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", h0.host_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write();
    send(0, C_HI, 4'h0);
    send(0, C_LO, 4'h5);
    send(0, C_WR, 4'hA);
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL wr_first_nibble_we: got %b required 0", mem_we);
    end
    send(0, C_WR, 4'h3);
    tests++;
    if (mem_we !== 1'b1 || mem_waddr !== 6'd5 || mem_wdata !== 8'hA3) begin
      fails++;
      $display("FAIL wr_commit: we=%b waddr=%0d wdata=%h required 1 5 a3",
               mem_we, mem_waddr, mem_wdata);
    end
    tests++;
    if (h0.host_ready !== 1'b0) begin
      fails++; $display("FAIL wr_ready_low: got %b required 0", h0.host_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (mem_we !== 1'b0 || h0.host_ready !== 1'b1 || mem_raddr !== 6'd6) begin
      fails++;
      $display("FAIL wr_after: we=%b ready=%b laddr=%0d required 0 1 6",
               mem_we, h0.host_ready, mem_raddr);
    end
    tests++;
    if (mem[5] !== 8'hA3) begin
      fails++; $display("FAIL wr_mem5: got %h required a3", mem[5]);
    end
  endtask

  task automatic test_wrap();
    send(0, C_HI, 4'h3);
    send(0, C_LO, 4'hF);
    send(0, C_WR, 4'h1);
    send(0, C_WR, 4'h1);
    send(0, C_WR, 4'h2);
    send(0, C_WR, 4'h2);
    tests++;
    if (mem_waddr !== 6'd0 || mem_wdata !== 8'h22) begin
      fails++;
      $display("FAIL wrap_waddr: waddr=%0d wdata=%h required 0 22", mem_waddr, mem_wdata);
    end
    @(posedge clk); #1;
    tests++;
    if (mem[63] !== 8'h11 || mem[0] !== 8'h22) begin
      fails++;
      $display("FAIL wrap_mem: mem63=%h mem0=%h required 11 22", mem[63], mem[0]);
    end
    tests++;
    if (mem_raddr !== 6'd1) begin
      fails++; $display("FAIL wrap_laddr: got %0d required 1", mem_raddr);
    end
  endtask

  task automatic test_read();
    send(0, C_HI, 4'h0);
    send(0, C_LO, 4'h2);
    send(0, C_WR, 4'h7);
    send(0, C_WR, 4'hC);
    send(0, C_HI, 4'h0);
    send(0, C_LO, 4'h2);
    send(0, C_CT, 4'h3);
    tests++;
    if (mem_raddr !== 6'd2 || h0.rd_valid !== 1'b0 || h0.host_ready !== 1'b0) begin
      fails++;
      $display("FAIL rd_state: raddr=%0d rd_valid=%b ready=%b required 2 0 0",
               mem_raddr, h0.rd_valid, h0.host_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (h0.rd_valid !== 1'b1 || h0.rd_data !== 8'h7C || mem_raddr !== 6'd3) begin
      fails++;
      $display("FAIL rd_data: rd_valid=%b rd_data=%h laddr=%0d required 1 7c 3",
               h0.rd_valid, h0.rd_data, mem_raddr);
    end
    @(posedge clk); #1;
    tests++;
    if (h0.rd_valid !== 1'b0) begin
      fails++; $display("FAIL rd_pulse_len: rd_valid=%b required 0", h0.rd_valid);
    end
  endtask

  task automatic test_run_limit();
    int high_cnt;
    int done_cnt;
    cpu_addr_l = 6'h2A;
    send(1, C_CT, 4'h1);
    tests++;
    if (running_l !== 1'b1 || cpu_reset_n_l !== 1'b1 || mem_raddr_l !== 6'h2A) begin
      fails++;
      $display("FAIL lim_start: running=%b cpu_rst_n=%b raddr=%h required 1 1 2a",
               running_l, cpu_reset_n_l, mem_raddr_l);
    end
    high_cnt = 1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        cpu_addr_l = 6'h11;
        #1;
        tests++;
        if (mem_raddr_l !== 6'h11) begin
          fails++; $display("FAIL lim_track: raddr=%h required 11", mem_raddr_l);
        end
      end
      if (cpu_reset_n_l) high_cnt++;
      if (done_l) begin
        done_cnt++;
        tests++;
        if (running_l !== 1'b0 || cpu_reset_n_l !== 1'b0) begin
          fails++;
          $display("FAIL lim_done_state: running=%b cpu_rst_n=%b required 0 0",
                   running_l, cpu_reset_n_l);
        end
      end
    end
    tests++;
    if (high_cnt != 10) begin
      fails++; $display("FAIL lim_cycles: got %0d required 10", high_cnt);
    end
    tests++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL lim_done_count: got %0d required 1", done_cnt);
    end
    tests++;
    if (running_l !== 1'b0 || mem_raddr_l !== 6'd0) begin
      fails++;
      $display("FAIL lim_end: running=%b raddr=%h required 0 00", running_l, mem_raddr_l);
    end
  endtask

  // Host HALT accepted on the very edge where the limit is reached.
  task automatic test_halt_at_limit();
    send(1, C_CT, 4'h1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    hl.host_valid = 1'b1; hl.host_cmd = C_CT; hl.host_data = 4'h0;
    @(posedge clk); #1;
    hl.host_valid = 1'b0;
    tests++;
    if (done_l !== 1'b1 || running_l !== 1'b0) begin
      fails++;
      $display("FAIL halt_at_limit: done=%b running=%b required 1 0", done_l, running_l);
    end
  endtask

  task automatic test_run_err();
    send(0, C_CT, 4'h1);
    tests++;
    if (running !== 1'b1 || cpu_reset_n !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL run_start: running=%b cpu_rst_n=%b err=%b required 1 1 0",
               running, cpu_reset_n, err);
    end
    cpu_addr = 6'h05;
    #1;
    tests++;
    if (mem_raddr !== 6'h05) begin
      fails++; $display("FAIL run_raddr: got %h required 05", mem_raddr);
    end
    send(0, C_WR, 4'h5);
    tests++;
    if (err !== 1'b1 || mem_we !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL run_err: err=%b we=%b running=%b required 1 0 1", err, mem_we, running);
    end
    send(0, C_WR, 4'h6);
    tests++;
    if (mem_we !== 1'b0) begin
      fails++; $display("FAIL run_no_write: we=%b required 0", mem_we);
    end
    send(0, C_CT, 4'h1);
    tests++;
    if (running !== 1'b1) begin
      fails++; $display("FAIL run_ctl_run_noop: running=%b required 1", running);
    end
    send(0, C_CT, 4'h0);
    tests++;
    if (running !== 1'b0 || cpu_reset_n !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
      fails++;
      $display("FAIL run_halt: running=%b cpu_rst_n=%b done=%b err=%b required 0 0 0 1",
               running, cpu_reset_n, done, err);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL run_halt_no_done: done=%b required 0", done);
    end
  endtask

  task automatic test_async_reset();
    send(0, C_CT, 4'h1);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (cpu_reset_n !== 1'b0 || running !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: cpu_rst_n=%b running=%b err=%b required 0 0 0",
               cpu_reset_n, running, err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (running !== 1'b0 || h0.host_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_after: running=%b ready=%b required 0 1", running, h0.host_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    h0.host_valid = 1'b0; h0.host_cmd = 2'b00; h0.host_data = 4'h0;
    hl.host_valid = 1'b0; hl.host_cmd = 2'b00; hl.host_data = 4'h0;
    cpu_addr   = 6'd0;
    cpu_addr_l = 6'd0;
    reset      = 1'b1;

    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_run_limit();
    test_halt_at_limit();
    test_run_err();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
